// File: rtl/pwm_pkg.sv
// Shared constants, channel mode type and decode helpers for the 16-channel PWM peripheral.
package pwm_pkg;

   localparam int PWM_CNT_W = 8;
   localparam int NUM_CH    = 16;

   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam logic [PWM_CNT_W-1:0] CNT_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      OFF         = 2'd0,
      STATIC_HIGH = 2'd1,
      PWM         = 2'd2
   } ch_mode_e;

   // The mode bit only matters once the channel is enabled.
   function automatic ch_mode_e decode_mode(input logic en_out, input logic en_pwm);
      ch_mode_e mode;
      if (!en_out) begin
         mode = OFF;
      end else if (!en_pwm) begin
         mode = STATIC_HIGH;
      end else begin
         mode = PWM;
      end
      return mode;
   endfunction

   // Full-scale duty pins the output high instead of leaving one low tick per period.
   function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                        input logic [PWM_CNT_W-1:0] duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: tick is high for one clk out of every PRESCALE (every clk when PRESCALE=1).
module pwm_prescaler #(
   parameter int PRESCALE = 13
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage fed by the SPI register block; each channel is off, high or PWM.
// Build option PWM_SYNC_UPDATE_EN: registers are shadowed and only take effect at period boundaries.
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   logic                 tick;
   logic [PWM_CNT_W-1:0] pwm_cnt;
   logic                 wrap;
   logic                 wrap_q;

   logic [NUM_CH-1:0]    en_out;
   logic [NUM_CH-1:0]    en_pwm;
   logic [NUM_CH-1:0]    eff_en_out;
   logic [NUM_CH-1:0]    eff_en_pwm;
   logic [PWM_CNT_W-1:0] eff_duty;

   logic                 pwm_high;
   logic [NUM_CH-1:0]    out_next;

   assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign wrap = tick && (pwm_cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
      end
   end

`ifdef PWM_SYNC_UPDATE_EN
   logic [PWM_CNT_W-1:0] shadow_duty;
   logic [NUM_CH-1:0]    shadow_en_out;
   logic [NUM_CH-1:0]    shadow_en_pwm;

   // Captured on wrap so the whole next period runs on one consistent configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_duty   <= '0;
         shadow_en_out <= '0;
         shadow_en_pwm <= '0;
      end else if (wrap) begin
         shadow_duty   <= pwm_duty_cycle;
         shadow_en_out <= en_out;
         shadow_en_pwm <= en_pwm;
      end
   end

   assign eff_duty   = shadow_duty;
   assign eff_en_out = shadow_en_out;
   assign eff_en_pwm = shadow_en_pwm;
`else
   assign eff_duty   = pwm_duty_cycle;
   assign eff_en_out = en_out;
   assign eff_en_pwm = en_pwm;
`endif

   assign pwm_high = pwm_compare(pwm_cnt, eff_duty);

   always_comb begin
      out_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (decode_mode(eff_en_out[i], eff_en_pwm[i]))
            OFF:         out_next[i] = 1'b0;
            STATIC_HIGH: out_next[i] = 1'b1;
            PWM:         out_next[i] = pwm_high;
            default:     out_next[i] = 1'b0;
         endcase
      end
   end

   // period_start is a one-clk strobe with no back-pressure: it is valid for exactly the clk in
   // which out first shows pwm_cnt==0 of a new period, and a consumer must sample it every clk.
   // wrap is delayed twice so the strobe lines up with the registered out, not with pwm_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q       <= 1'b0;
         period_start <= 1'b0;
         out          <= '0;
      end else begin
         wrap_q       <= wrap;
         period_start <= wrap_q;
         out          <= out_next;
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Period-level scoreboard bench for pwm_peripheral at PRESCALE=13; builds with or without PWM_SYNC_UPDATE_EN.
module tb_pwm_peripheral;

   localparam int PRESCALE    = 13;
   localparam int PERIOD_CLKS = 256 * PRESCALE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  en_reg_out_7_0 = 8'hFF;
   logic [7:0]  en_reg_out_15_8 = 8'hFF;
   logic [7:0]  en_reg_pwm_7_0 = 8'hFF;
   logic [7:0]  en_reg_pwm_15_8 = 8'hFF;
   logic [7:0]  pwm_duty_cycle = 8'hFF;
   logic [15:0] out;
   logic        period_start;

   int checks = 0;
   int errors = 0;

   // {period_len[79:64], out0_high[63:48], out15_high[47:32], or_of_out[31:16], and_of_out[15:0]}
   logic [79:0] exp_q[$];

   int          mon_len;
   int          mon_hi0;
   int          mon_hi15;
   logic [15:0] mon_or;
   logic [15:0] mon_and;
   logic        mon_active = 1'b0;

   pwm_peripheral #(
      .PRESCALE (PRESCALE)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
      en_reg_out_7_0  = eo[7:0];
      en_reg_out_15_8 = eo[15:8];
      en_reg_pwm_7_0  = ep[7:0];
      en_reg_pwm_15_8 = ep[15:8];
      pwm_duty_cycle  = duty;
   endtask

   task automatic push_exp(input logic [15:0] len, input logic [15:0] hi0, input logic [15:0] hi15,
                           input logic [15:0] or_v, input logic [15:0] and_v);
      exp_q.push_back({len, hi0, hi15, or_v, and_v});
   endtask

   // Returns #1 after the posedge that raised period_start.
   task automatic wait_ps();
      for (int n = 0; n < PERIOD_CLKS + 16; n++) begin
         @(posedge clk);
         #1;
         if (period_start) return;
      end
      checks++;
      errors++;
      $display("FAIL period_start_timeout: got none within %0d clk required one", PERIOD_CLKS + 16);
   endtask

   // First period after a config change is discarded; the following full period is scored.
   task automatic run_case(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty,
                           input logic [15:0] hi0, input logic [15:0] hi15,
                           input logic [15:0] or_v, input logic [15:0] and_v);
      set_cfg(eo, ep, duty);
      wait_ps();
      wait_ps();
      push_exp(16'(PERIOD_CLKS), hi0, hi15, or_v, and_v);
      wait_ps();
   endtask

   // Monitor: a window runs from one period_start to the next and is scored against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_active = 1'b0;
         end else begin
            if (period_start) begin
               if (mon_active) begin
                  logic [79:0] exp_v;
                  exp_v = exp_q.pop_front();
                  check("period_len",  32'(mon_len),  32'(exp_v[79:64]));
                  check("out0_high",   32'(mon_hi0),  32'(exp_v[63:48]));
                  check("out15_high",  32'(mon_hi15), 32'(exp_v[47:32]));
                  check("out_or",      32'(mon_or),   32'(exp_v[31:16]));
                  check("out_and",     32'(mon_and),  32'(exp_v[15:0]));
               end
               mon_active = (exp_q.size() > 0);
               mon_len  = 0;
               mon_hi0  = 0;
               mon_hi15 = 0;
               mon_or   = 16'h0000;
               mon_and  = 16'hFFFF;
            end
            if (mon_active) begin
               mon_len++;
               if (out[0])  mon_hi0++;
               if (out[15]) mon_hi15++;
               mon_or  = mon_or | out;
               mon_and = mon_and & out;
            end
         end
      end
   end

   initial begin
      int n;

      // Reset with every input at 0xFF.
      #2 rst_n = 1'b0;
      #1;
      check("reset_out_async", 32'(out), 32'h0);
      check("reset_ps_async",  32'(period_start), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_held", 32'(out), 32'h0);
      check("reset_ps_held",  32'(period_start), 32'h0);

      // Static channel 0 from reset.
      set_cfg(16'h0001, 16'h0000, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
`ifdef PWM_SYNC_UPDATE_EN
      check("static_before_first_period", 32'(out), 32'h0000);
`else
      check("static_immediate", 32'(out), 32'h0001);
`endif
      wait_ps();
      push_exp(16'd3328, 16'd3328, 16'd0, 16'h0001, 16'h0001);
      wait_ps();

      // Half duty: 128 ticks x 13 clk high.
      run_case(16'h8001, 16'h8001, 8'h80, 16'd1664, 16'd1664, 16'h8001, 16'h0000);

      // Duty 0x00: PWM channels never high.
      run_case(16'h8001, 16'h8001, 8'h00, 16'd0, 16'd0, 16'h0000, 16'h0000);

      // Duty 0xFF: constantly high over two consecutive periods.
      set_cfg(16'h8001, 16'h8001, 8'hFF);
      wait_ps();
      wait_ps();
      push_exp(16'd3328, 16'd3328, 16'd3328, 16'h8001, 16'h8001);
      wait_ps();
      push_exp(16'd3328, 16'd3328, 16'd3328, 16'h8001, 16'h8001);
      wait_ps();

      // Enable gates mode: PWM bits alone do nothing.
      run_case(16'h0000, 16'hFFFF, 8'hFF, 16'd0, 16'd0, 16'h0000, 16'h0000);
      run_case(16'h00FF, 16'hFFFF, 8'hFF, 16'd3328, 16'd0, 16'h00FF, 16'h00FF);

      // Duty 0x40 -> 0xC0 in the first clk of pwm_cnt=100 (window clk 1300).
      set_cfg(16'h8001, 16'h8001, 8'h40);
      wait_ps();
      wait_ps();
`ifdef PWM_SYNC_UPDATE_EN
      push_exp(16'd3328, 16'd832, 16'd832, 16'h8001, 16'h0000);
`else
      push_exp(16'd3328, 16'd2028, 16'd2028, 16'h8001, 16'h0000);
`endif
      repeat (1299) @(posedge clk);
      #1;
      pwm_duty_cycle = 8'hC0;
      wait_ps();
      push_exp(16'd3328, 16'd2496, 16'd2496, 16'h8001, 16'h0000);
      wait_ps();

      // Reset mid-period while every channel is static high.
      set_cfg(16'hFFFF, 16'h0000, 8'h00);
      wait_ps();
      wait_ps();
      repeat (500) @(posedge clk);
      #1;
      check("mid_period_all_high", 32'(out), 32'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_out_async", 32'(out), 32'h0);
      check("mid_reset_ps_async",  32'(period_start), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Counting restarts from 0: first period_start after 256*13 + 1 posedges.
      n = 0;
      for (int k = 0; k < PERIOD_CLKS + 16; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (period_start) break;
      end
      check("first_period_start_after_reset", 32'(n), 32'd3329);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
